riscv_bp_ctrl: RTL
==================

Name: riscv_bp_ctrl

Overview:
Branch-prediction controller feeding the pre-decode stage's bp_bp_predict_i. It owns a single-port table of 2-bit saturating counters indexed by PC. It arbitrates that one port between fetch-side lookups and branch-unit updates, using a 1-entry update buffer with forwarding. A state machine initialises the table after reset and on a clear request.

Parameters:
XLEN, 32, address/PC width
BP_LOCAL_BITS, 6, table index width; table depth = 2**BP_LOCAL_BITS
BP_LSB, 2, lowest PC bit used for the index

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
id_stall_i  in  1  pipeline stall; hold output, suppress lookup
bp_clear_i  in  1  re-initialise table (fence.i/CSR)
if_nxt_pc_i  in  XLEN  PC being fetched next
if_nxt_pc_vld_i  in  1  lookup request
bp_bp_predict_o  out  2  registered prediction for instruction arriving next cycle
bu_bp_update_i  in  1  branch resolved, update request
bu_bp_pc_i  in  XLEN  PC of resolved branch
bu_bp_predict_i  in  2  counter value originally predicted (carried down the pipe)
bu_bp_btaken_i  in  1  branch actually taken
bp_busy_o  out  1  table initialising

Behaviour:
- Index = pc[BP_LSB +: BP_LOCAL_BITS] for both lookup and update.
- FSM states: INIT, RUN.
- Reset (rst_ni=0 at clk edge): state=INIT, init index=0, buffer invalid, bp_bp_predict_o=2'b00, bp_busy_o=1.
- INIT:
  - Writes 2'b01 (weakly not-taken) to entry init index each cycle; index increments.
  - After writing the last entry (index=2**BP_LOCAL_BITS-1), state goes to RUN next cycle.
  - Init takes exactly 2**BP_LOCAL_BITS cycles.
  - bp_busy_o=1 throughout INIT.
  - Updates are dropped. Lookups load bp_bp_predict_o=2'b00 unless id_stall_i.
  - bp_clear_i in INIT restarts at index 0.
- RUN: bp_busy_o=0.
  - bp_clear_i: invalidate buffer, state=INIT, index=0 next cycle. Clear wins over all other requests that cycle.
- Update value: new = btaken ? sat_inc(bu_bp_predict_i) : sat_dec(bu_bp_predict_i). Saturates at 2'b11 and 2'b00. Write-only; no table read needed.
- Lookup is active when if_nxt_pc_vld_i & ~id_stall_i.
- When id_stall_i=1, bp_bp_predict_o holds its value and the cycle counts as having no lookup.
- Port arbitration in RUN, evaluated in this priority order each cycle:
  1. Buffer valid and new update arrives: write the buffer entry to the table, load the new update into the buffer. Any active lookup is lost and bp_bp_predict_o=2'b00.
  2. Active lookup: read the table and register the result into bp_bp_predict_o (latency 1). A new update, if any, goes into the empty buffer.
  3. No lookup: write the buffer entry if valid (buffer becomes invalid), else write the incoming update directly.
- Forwarding: active lookup index equals the valid buffer index → output the buffer data instead of the table data.
  - An update arriving in the same cycle as a lookup of the same index is NOT forwarded; it becomes visible from the next lookup.
- No update is ever lost in RUN except via bp_clear_i or reset.
- Reset mid-operation: the FSM restarts INIT regardless of state. Table contents are overwritten by init.

Test Plan:
- Reset, hold 70 cycles with lookups of pc 0x200 → bp_busy_o=1 for exactly 64 cycles, output 2'b00 during init, then a lookup of 0x200 returns 2'b01 one cycle after request.
- After init, no lookups; update pc 0x204 with predict=01, taken=1; next cycle update predict=10, taken=1; then lookup 0x204 → 2'b11. Further update predict=11, taken=1, then lookup → 2'b11 (saturation). Same with not-taken from 00 → 00.
- Continuous lookups of 0x300; update pc 0x300 predict=01 taken=1 in cycle t → update held in buffer; lookup 0x300 at t+1 returns forwarded 2'b10. Lookup 0x300 at t (same cycle) returns 2'b01.
- Continuous lookups, updates on two consecutive cycles (pc 0x208, then 0x20C) → second cycle drops the lookup (output 2'b00). Later lookups return updated 0x208 and 0x20C values once written.
- id_stall_i=1 for 3 cycles with a pending buffered update → bp_bp_predict_o unchanged, buffer drained to table during the stall, and subsequent lookup returns the written value.
- Assert bp_clear_i in RUN with a buffered update; separately assert rst_ni=0 at init index 20 → both re-enter INIT at index 0 and run 64 cycles. Buffered update is discarded and all entries read 2'b01 afterwards.

Source files
------------

// File: rtl/riscv_bp_ctrl_if.sv
// Port bundle between the fetch/branch units and the branch-prediction controller.
interface riscv_bp_ctrl_if #(
  parameter int XLEN = 32
);
  logic            id_stall_i;
  logic            bp_clear_i;
  logic [XLEN-1:0] if_nxt_pc_i;
  logic            if_nxt_pc_vld_i;
  logic [1:0]      bp_bp_predict_o;
  logic            bu_bp_update_i;
  logic [XLEN-1:0] bu_bp_pc_i;
  logic [1:0]      bu_bp_predict_i;
  logic            bu_bp_btaken_i;
  logic            bp_busy_o;

  modport slave (
    input  id_stall_i, bp_clear_i, if_nxt_pc_i, if_nxt_pc_vld_i,
           bu_bp_update_i, bu_bp_pc_i, bu_bp_predict_i, bu_bp_btaken_i,
    output bp_bp_predict_o, bp_busy_o
  );

  modport master (
    output id_stall_i, bp_clear_i, if_nxt_pc_i, if_nxt_pc_vld_i,
           bu_bp_update_i, bu_bp_pc_i, bu_bp_predict_i, bu_bp_btaken_i,
    input  bp_bp_predict_o, bp_busy_o
  );
endinterface

// File: rtl/riscv_bp_ctrl.sv
// 2-bit counter branch predictor: single-port table shared between lookups and
// updates, with a 1-entry forwarding update buffer and an init/clear sweep FSM.
module riscv_bp_ctrl #(
  parameter int XLEN          = 32,
  parameter int BP_LOCAL_BITS = 6,
  parameter int BP_LSB        = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  riscv_bp_ctrl_if.slave    bp
);
  localparam int DEPTH = 2**BP_LOCAL_BITS;
  localparam logic [BP_LOCAL_BITS-1:0] LAST_IDX = {BP_LOCAL_BITS{1'b1}};

  typedef enum logic {INIT, RUN} state_e;

  typedef struct packed {
    logic [BP_LOCAL_BITS-1:0] idx;
    logic [1:0]               cnt;
  } upd_t;

  state_e                   state_q, state_d;
  logic [BP_LOCAL_BITS-1:0] init_idx_q, init_idx_d;
  logic                     buf_vld_q, buf_vld_d;
  upd_t                     buf_q, buf_d;
  logic [1:0]               pred_q, pred_d;
  logic [1:0]               tbl_q [DEPTH];

  logic                     wr_en;
  logic [BP_LOCAL_BITS-1:0] wr_idx;
  logic [1:0]               wr_data;

  logic                     lookup;
  logic [BP_LOCAL_BITS-1:0] lk_idx;
  upd_t                     upd_new;

  assign lookup  = bp.if_nxt_pc_vld_i & ~bp.id_stall_i;
  assign lk_idx  = bp.if_nxt_pc_i[BP_LSB +: BP_LOCAL_BITS];

  // The new counter value depends only on the predicted value carried down the pipe.
  always_comb begin
    upd_new.idx = bp.bu_bp_pc_i[BP_LSB +: BP_LOCAL_BITS];
    if (bp.bu_bp_btaken_i)
      upd_new.cnt = (bp.bu_bp_predict_i == 2'b11) ? 2'b11 : bp.bu_bp_predict_i + 2'b01;
    else
      upd_new.cnt = (bp.bu_bp_predict_i == 2'b00) ? 2'b00 : bp.bu_bp_predict_i - 2'b01;
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    buf_vld_d  = buf_vld_q;
    buf_d      = buf_q;
    pred_d     = pred_q;
    wr_en      = 1'b0;
    wr_idx     = init_idx_q;
    wr_data    = 2'b01;
    unique case (state_q)
      INIT: begin
        wr_en     = 1'b1;
        buf_vld_d = 1'b0;
        if (lookup) pred_d = 2'b00;
        if (bp.bp_clear_i) begin
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
          if (init_idx_q == LAST_IDX) state_d = RUN;
        end
      end
      RUN: begin
        if (bp.bp_clear_i) begin
          state_d    = INIT;
          init_idx_d = '0;
          buf_vld_d  = 1'b0;
        end else if (buf_vld_q && bp.bu_bp_update_i) begin
          // Port is taken by the buffer drain; the lookup is sacrificed.
          wr_en   = 1'b1;
          wr_idx  = buf_q.idx;
          wr_data = buf_q.cnt;
          buf_d   = upd_new;
          if (lookup) pred_d = 2'b00;
        end else if (lookup) begin
          pred_d = (buf_vld_q && buf_q.idx == lk_idx) ? buf_q.cnt : tbl_q[lk_idx];
          if (bp.bu_bp_update_i) begin
            buf_vld_d = 1'b1;
            buf_d     = upd_new;
          end
        end else if (buf_vld_q) begin
          wr_en     = 1'b1;
          wr_idx    = buf_q.idx;
          wr_data   = buf_q.cnt;
          buf_vld_d = 1'b0;
        end else if (bp.bu_bp_update_i) begin
          wr_en   = 1'b1;
          wr_idx  = upd_new.idx;
          wr_data = upd_new.cnt;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      buf_vld_q  <= 1'b0;
      buf_q      <= '0;
      pred_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      buf_vld_q  <= buf_vld_d;
      buf_q      <= buf_d;
      pred_q     <= pred_d;
    end
  end

  // Table needs no reset: the init sweep rewrites every entry.
  always_ff @(posedge clk_i) begin
    if (wr_en) tbl_q[wr_idx] <= wr_data;
  end

  assign bp.bp_bp_predict_o = pred_q;
  assign bp.bp_busy_o       = (state_q == INIT);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.if_nxt_pc_i[XLEN-1:BP_LSB+BP_LOCAL_BITS], bp.if_nxt_pc_i[BP_LSB-1:0],
                            bp.bu_bp_pc_i[XLEN-1:BP_LSB+BP_LOCAL_BITS], bp.bu_bp_pc_i[BP_LSB-1:0]};
endmodule
